// File: rtl/pma_tx_serializer.sv
// PMA transmit serializer: valid/ready word intake, one-word holding register, gapless LSB/MSB-first output.
// Optional PRBS7 test-pattern state is compiled in when PMA_TX_PRBS_EN is defined.
module pma_tx_serializer #(
  parameter int DATA_WIDTH = 10,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic                  Bit_Rate_Clk,
  input  logic                  Rst_n,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  Data_Valid,
`ifdef PMA_TX_PRBS_EN
  input  logic                  Prbs_En,
`endif
  output logic                  Data_Ready,
  output logic                  TX_Out_P,
  output logic                  TX_Out_N,
  output logic                  Word_Strobe,
  output logic                  Underrun,
  output logic                  Tx_Active
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

`ifdef PMA_TX_PRBS_EN
  localparam logic [6:0] PRBS_SEED = 7'h7F;
  typedef enum logic [1:0] {ST_IDLE, ST_TRANSMIT, ST_PRBS} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_TRANSMIT} state_t;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  hold_vld;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         cnt;
  logic                  tx_bit;
  logic                  strobe_r;
  logic                  underrun_r;
  logic                  at_boundary;
  logic                  load_evt;
  logic                  accept;
  logic                  intake_open;
`ifdef PMA_TX_PRBS_EN
  logic [6:0]            lfsr;
  logic                  prbs_go;
`endif

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

`ifdef PMA_TX_PRBS_EN
  function automatic logic [6:0] prbs_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction
`endif

  // A new word may start from idle or exactly on the last bit of the current word; PRBS request wins.
  always_comb begin
    at_boundary = (state == ST_IDLE) || (cnt == LAST_CNT);
`ifdef PMA_TX_PRBS_EN
    prbs_go     = at_boundary && Prbs_En;
    load_evt    = hold_vld && at_boundary && !Prbs_En;
    intake_open = (state != ST_PRBS);
`else
    load_evt    = hold_vld && at_boundary;
    intake_open = 1'b1;
`endif
    Data_Ready  = Rst_n && intake_open && (!hold_vld || load_evt);
    accept      = Data_Valid && Data_Ready;
  end

  assign TX_Out_P    = tx_bit;
  assign TX_Out_N    = ~tx_bit;
  assign Word_Strobe = strobe_r;
  assign Underrun    = underrun_r;
  assign Tx_Active   = (state != ST_IDLE);

  always_ff @(posedge Bit_Rate_Clk) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      hold_reg   <= '0;
      hold_vld   <= 1'b0;
      shift_reg  <= '0;
      cnt        <= '0;
      tx_bit     <= IDLE_BIT;
      strobe_r   <= 1'b0;
      underrun_r <= 1'b0;
`ifdef PMA_TX_PRBS_EN
      lfsr       <= PRBS_SEED;
`endif
    end else begin
      strobe_r   <= 1'b0;
      underrun_r <= 1'b0;

      // Write-through: a word accepted on the load edge refills the holding register just vacated.
      if (accept) begin
        hold_reg <= Data_in;
        hold_vld <= 1'b1;
      end else if (load_evt) begin
        hold_vld <= 1'b0;
      end

      if (load_evt) begin
        state     <= ST_TRANSMIT;
        shift_reg <= advance(hold_reg);
        tx_bit    <= first_bit(hold_reg);
        cnt       <= '0;
        strobe_r  <= 1'b1;
`ifdef PMA_TX_PRBS_EN
      end else if (prbs_go) begin
        cnt   <= '0;
        state <= ST_PRBS;
        if (state == ST_PRBS) begin
          tx_bit <= lfsr[6];
          lfsr   <= prbs_step(lfsr);
        end else begin
          tx_bit <= PRBS_SEED[6];
          lfsr   <= prbs_step(PRBS_SEED);
        end
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            tx_bit <= IDLE_BIT;
            cnt    <= '0;
          end
          ST_TRANSMIT: begin
            if (cnt == LAST_CNT) begin
              state      <= ST_IDLE;
              tx_bit     <= IDLE_BIT;
              cnt        <= '0;
              underrun_r <= 1'b1;
            end else begin
              cnt       <= cnt + CW'(1);
              tx_bit    <= first_bit(shift_reg);
              shift_reg <= advance(shift_reg);
            end
          end
`ifdef PMA_TX_PRBS_EN
          // Leaving PRBS with nothing queued is a deliberate stop, not an underrun.
          ST_PRBS: begin
            if (cnt == LAST_CNT) begin
              state  <= ST_IDLE;
              tx_bit <= IDLE_BIT;
              cnt    <= '0;
            end else begin
              cnt    <= cnt + CW'(1);
              tx_bit <= lfsr[6];
              lfsr   <= prbs_step(lfsr);
            end
          end
`endif
          default: begin
            state  <= ST_IDLE;
            tx_bit <= IDLE_BIT;
            cnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pma_tx_serializer.sv
// Bench for pma_tx_serializer: per-cycle vector table for reset/single-word/abort,
// scoreboard of accepted words for back-to-back and backpressure traffic, PRBS checks under PMA_TX_PRBS_EN.
module tb_pma_tx_serializer;

  localparam int W = 10;

  logic         Bit_Rate_Clk = 1'b0;
  logic         Rst_n;
  logic [W-1:0] Data_in;
  logic         Data_Valid;
  logic         prbs_en;
  logic         Data_Ready, TX_Out_P, TX_Out_N, Word_Strobe, Underrun, Tx_Active;
  logic         ready_m, txp_m, txn_m, strobe_m, underrun_m, active_m;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always #5 Bit_Rate_Clk = ~Bit_Rate_Clk;
  always @(posedge Bit_Rate_Clk) cyc <= cyc + 1;

  pma_tx_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut (
    .Bit_Rate_Clk(Bit_Rate_Clk), .Rst_n(Rst_n), .Data_in(Data_in), .Data_Valid(Data_Valid),
`ifdef PMA_TX_PRBS_EN
    .Prbs_En(prbs_en),
`endif
    .Data_Ready(Data_Ready), .TX_Out_P(TX_Out_P), .TX_Out_N(TX_Out_N),
    .Word_Strobe(Word_Strobe), .Underrun(Underrun), .Tx_Active(Tx_Active)
  );

  pma_tx_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .Bit_Rate_Clk(Bit_Rate_Clk), .Rst_n(Rst_n), .Data_in(Data_in), .Data_Valid(Data_Valid),
`ifdef PMA_TX_PRBS_EN
    .Prbs_En(prbs_en),
`endif
    .Data_Ready(ready_m), .TX_Out_P(txp_m), .TX_Out_N(txn_m),
    .Word_Strobe(strobe_m), .Underrun(underrun_m), .Tx_Active(active_m)
  );

  // One row = inputs held across one rising edge, expected outputs just after it.
  // exp packs {Data_Ready, TX_Out_P, TX_Out_N, Word_Strobe, Underrun, Tx_Active}.
  typedef struct {
    logic         rst_n;
    logic         valid;
    logic [W-1:0] data;
    logic [5:0]   exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] mk(input logic rdy, input logic p, input logic s,
                                    input logic u, input logic a);
    return {rdy, p, ~p, s, u, a};
  endfunction

  task automatic addVec(input logic r, input logic v, input logic [W-1:0] d, input logic [5:0] e);
    vec_t t;
    t.rst_n = r; t.valid = v; t.data = d; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d);
    Rst_n      = r;
    Data_Valid = v;
    Data_in    = d;
    @(posedge Bit_Rate_Clk);
    #1;
  endtask

  task automatic checkOutput(input int row, input logic [5:0] exp);
    logic [5:0] got;
    got = {Data_Ready, TX_Out_P, TX_Out_N, Word_Strobe, Underrun, Tx_Active};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL vec_row%0d {rdy,p,n,strb,undr,act} got=%b exp=%b", row, got, exp);
    end
  endtask

  // Scoreboard: words pushed on handshake, popped when a word strobe appears on the line.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] send_q[$];
  logic [W-1:0] cur_word, cap_l, cap_m;
  bit           sb_on = 1'b0;
  bit           in_word = 1'b0;
  int           bit_idx = 0;
  int           strobe_cnt = 0;
  int           underrun_cnt = 0;
  int           gap_bad = 0;
  int           last_strobe = 0;

  always @(negedge Bit_Rate_Clk) begin
    if (sb_on) begin
      if (Underrun) begin
        underrun_cnt++;
        tests_run++;
        if (cyc - last_strobe != W) begin
          tests_failed++;
          $display("[TB] FAIL underrun_timing cycles_after_strobe=%0d exp=%0d", cyc - last_strobe, W);
        end
      end
      if (Word_Strobe) begin
        tests_run++;
        if (in_word) begin
          tests_failed++;
          $display("[TB] FAIL strobe_mid_word at_bit=%0d exp_bit=%0d", bit_idx, W);
        end
        if (strobe_cnt > 0 && cyc - last_strobe != W) gap_bad++;
        strobe_cnt++;
        last_strobe = cyc;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_word queue_size=0 exp=nonzero");
          in_word = 1'b0;
        end else begin
          cur_word = exp_q.pop_front();
          in_word  = 1'b1;
          bit_idx  = 0;
        end
      end
      if (in_word) begin
        cap_l[bit_idx]       = TX_Out_P;
        cap_m[W-1-bit_idx]   = txp_m;
        bit_idx++;
        if (bit_idx == W) begin
          in_word = 1'b0;
          tests_run++;
          if (cap_l !== cur_word || cap_m !== cur_word) begin
            tests_failed++;
            $display("[TB] FAIL word_data lsb_first=%h msb_first=%h exp=%h", cap_l, cap_m, cur_word);
          end
        end
      end
    end
  end

  task automatic sendWords(input int exp_iters, input string tag);
    int  idx;
    int  iters;
    bit  acc;
    idx   = 0;
    iters = 0;
    while (idx < send_q.size() && iters < 200) begin
      Data_Valid = 1'b1;
      Data_in    = send_q[idx];
      @(negedge Bit_Rate_Clk);
      acc = Data_Ready;
      @(posedge Bit_Rate_Clk);
      #1;
      if (acc) begin
        exp_q.push_back(send_q[idx]);
        idx++;
      end
      iters++;
    end
    Data_Valid = 1'b0;
    tests_run++;
    if (iters != exp_iters) begin
      tests_failed++;
      $display("[TB] FAIL %s_accept_cycles got=%0d exp=%0d", tag, iters, exp_iters);
    end
  endtask

  task automatic waitDrain(input int n_words, input string tag);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || in_word) && guard < 100) begin
      @(posedge Bit_Rate_Clk);
      guard++;
    end
    repeat (4) @(posedge Bit_Rate_Clk);
    #1;
    tests_run++;
    if (guard >= 100) begin
      tests_failed++;
      $display("[TB] FAIL %s_drain words_left=%0d exp=0", tag, exp_q.size());
    end
    tests_run++;
    if (strobe_cnt != n_words || gap_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_strobes got=%0d gaps=%0d exp=%0d gaps=0", tag, strobe_cnt, gap_bad, n_words);
    end
    tests_run++;
    if (underrun_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL %s_underruns got=%0d exp=1", tag, underrun_cnt);
    end
  endtask

  task automatic resetCounters();
    strobe_cnt   = 0;
    underrun_cnt = 0;
    gap_bad      = 0;
  endtask

`ifdef PMA_TX_PRBS_EN
  logic prbs_bits [160];
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] w;
    Rst_n      = 1'b0;
    Data_Valid = 1'b1;
    Data_in    = 10'h064;
    prbs_en    = 1'b0;

    // Reset with valid asserted, then single word 0x064 LSB first.
    addVec(1'b0, 1'b1, 10'h064, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    addVec(1'b0, 1'b1, 10'h064, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    addVec(1'b1, 1'b1, 10'h064, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    w = 10'h064;
    for (int i = 0; i < W; i++)
      addVec(1'b1, 1'b0, 10'h000, mk(1'b1, w[i], (i == 0), 1'b0, 1'b1));
    addVec(1'b1, 1'b0, 10'h000, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    addVec(1'b1, 1'b0, 10'h000, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    // Word 0x3FF with 0x2AA held behind it, reset at cnt=4 aborts both.
    addVec(1'b1, 1'b1, 10'h3FF, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    addVec(1'b1, 1'b1, 10'h2AA, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    for (int i = 1; i <= 4; i++)
      addVec(1'b1, 1'b0, 10'h000, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    addVec(1'b0, 1'b0, 10'h000, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      addVec(1'b1, 1'b0, 10'h000, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].data);
      checkOutput(i, vecs[i].exp);
    end

    // Back-to-back words with valid held: 3 gapless words, one underrun at the end.
    sb_on = 1'b1;
    resetCounters();
    send_q = '{10'h064, 10'h0C8, 10'h01E};
    sendWords(12, "btb");
    waitDrain(3, "btb");

    // Backpressure: five words offered continuously, accepted only at empty/load edges.
    resetCounters();
    send_q = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
    sendWords(32, "bp");
    waitDrain(5, "bp");
    sb_on = 1'b0;

`ifdef PMA_TX_PRBS_EN
    begin
      int   n;
      bit   per_ok;
      Data_Valid = 1'b0;
      prbs_en    = 1'b1;
      for (int k = 1; k <= 143; k++) begin
        @(posedge Bit_Rate_Clk);
        #1;
        prbs_bits[k-1] = TX_Out_P;
        if (k == 5) begin
          tests_run++;
          if (Data_Ready !== 1'b0 || Tx_Active !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL prbs_ready_active got=%b%b exp=01", Data_Ready, Tx_Active);
          end
        end
      end
      tests_run++;
      if ({prbs_bits[0], prbs_bits[1], prbs_bits[2], prbs_bits[3], prbs_bits[4], prbs_bits[5],
           prbs_bits[6], prbs_bits[7]} !== 8'b1111_1110) begin
        tests_failed++;
        $display("[TB] FAIL prbs_first8 got=%b%b%b%b%b%b%b%b exp=11111110", prbs_bits[0], prbs_bits[1],
                 prbs_bits[2], prbs_bits[3], prbs_bits[4], prbs_bits[5], prbs_bits[6], prbs_bits[7]);
      end
      per_ok = 1'b1;
      for (int i = 0; i < 16; i++)
        if (prbs_bits[i] !== prbs_bits[i+127]) per_ok = 1'b0;
      tests_run++;
      if (!per_ok) begin
        tests_failed++;
        $display("[TB] FAIL prbs_period127 got=mismatch_in_first16 exp=repeat");
      end
      prbs_en = 1'b0;
      n = 143;
      while (Tx_Active && n < 180) begin
        @(posedge Bit_Rate_Clk);
        #1;
        n++;
      end
      tests_run++;
      if (n != 151 || Underrun !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL prbs_exit edge=%0d underrun=%b exp=151 underrun=0", n, Underrun);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
